// File: rtl/snow64_float_mul_param.sv
// Parameterized sequential float multiplier. Specials resolve in one edge.
// Normal operands go through a SIG_W-cycle shift-add multiplier.
module snow64_float_mul_param #(
  parameter int EXP_WIDTH     = 8,
  parameter int MANT_WIDTH    = 7,
  parameter int ROUND_NEAREST = 0,
  localparam int W            = 1 + EXP_WIDTH + MANT_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         can_accept_cmd,
  output logic         data_valid,
  output logic [W-1:0] data
);
  localparam int SIG_W  = MANT_WIDTH + 1;
  localparam int PW     = 2 * SIG_W;
  localparam int EW     = EXP_WIDTH + 2;
  localparam int CW     = $clog2(SIG_W + 1);
  localparam int BIAS_I = (1 << (EXP_WIDTH - 1)) - 1;
  localparam int EMAX_I = (1 << EXP_WIDTH) - 1;
  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS_I);
  localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX_I);

  typedef enum logic [1:0] {StIdle, StMultiplying, StFinishing} state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          mcand_q, mcand_d;
  logic [SIG_W-1:0]       mplier_q, mplier_d;
  logic [PW-1:0]          prod_q, prod_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [EW-1:0]   exp_q, exp_d;
  logic                   sign_q, sign_d;
  logic                   spec_q, spec_d;
  logic [W-1:0]           spec_res_q, spec_res_d;
  logic [W-1:0]           data_q, data_d;
  logic                   data_valid_q, data_valid_d;

  // Operand classification
  logic [EXP_WIDTH-1:0]  ea, eb;
  logic [MANT_WIDTH-1:0] ma, mb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, in_sign;
  assign ea      = a[W-2 -: EXP_WIDTH];
  assign eb      = b[W-2 -: EXP_WIDTH];
  assign ma      = a[MANT_WIDTH-1:0];
  assign mb      = b[MANT_WIDTH-1:0];
  assign a_zero  = (ea == '0);
  assign b_zero  = (eb == '0);
  assign a_inf   = (&ea) && (ma == '0);
  assign b_inf   = (&eb) && (mb == '0);
  assign a_nan   = (&ea) && (ma != '0);
  assign b_nan   = (&eb) && (mb != '0);
  assign in_sign = a[W-1] ^ b[W-1];

  // Normalise / round / range-check the finished product
  logic [PW-1:0]         pn;
  logic [MANT_WIDTH-1:0] mant, mant_f;
  logic [MANT_WIDTH:0]   mant_r;
  logic                  guard, sticky, inc;
  logic signed [EW-1:0]  e1, e2;
  logic [W-1:0]          norm_res;

  always_comb begin
    pn     = prod_q[PW-1] ? prod_q : (prod_q << 1);
    e1     = exp_q + {{(EW-1){1'b0}}, prod_q[PW-1]};
    mant   = pn[PW-2 -: MANT_WIDTH];
    guard  = pn[MANT_WIDTH];
    sticky = |pn[MANT_WIDTH-1:0];
    inc    = (ROUND_NEAREST != 0) && guard && (sticky || mant[0]);
    mant_r = {1'b0, mant} + {{MANT_WIDTH{1'b0}}, inc};
    mant_f = mant_r[MANT_WIDTH] ? '0 : mant_r[MANT_WIDTH-1:0];
    e2     = e1 + {{(EW-1){1'b0}}, mant_r[MANT_WIDTH]};
    if (e2 >= EMAX_S)
      norm_res = {sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    else if (e2 <= 0)
      norm_res = {sign_q, {(W-1){1'b0}}};
    else
      norm_res = {sign_q, e2[EXP_WIDTH-1:0], mant_f};
  end

  always_comb begin
    state_d      = state_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    prod_d       = prod_q;
    cnt_d        = cnt_q;
    exp_d        = exp_q;
    sign_d       = sign_q;
    spec_d       = spec_q;
    spec_res_d   = spec_res_q;
    data_d       = data_q;
    data_valid_d = 1'b0;
    case (state_q)
      StIdle: if (start) begin
        sign_d = in_sign;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          spec_d     = 1'b1;
          spec_res_d = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
          state_d    = StFinishing;
        end else if (a_inf || b_inf) begin
          spec_d     = 1'b1;
          spec_res_d = {in_sign, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
          state_d    = StFinishing;
        end else if (a_zero || b_zero) begin
          spec_d     = 1'b1;
          spec_res_d = {in_sign, {(W-1){1'b0}}};
          state_d    = StFinishing;
        end else begin
          spec_d   = 1'b0;
          mcand_d  = {{SIG_W{1'b0}}, 1'b1, ma};
          mplier_d = {1'b1, mb};
          prod_d   = '0;
          cnt_d    = CW'(SIG_W);
          exp_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S;
          state_d  = StMultiplying;
        end
      end
      StMultiplying: begin
        // One multiplier bit per cycle, LSB first
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = StFinishing;
      end
      StFinishing: begin
        data_d       = spec_q ? spec_res_q : norm_res;
        data_valid_d = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mcand_q      <= '0;
      mplier_q     <= '0;
      prod_q       <= '0;
      cnt_q        <= '0;
      exp_q        <= '0;
      sign_q       <= 1'b0;
      spec_q       <= 1'b0;
      spec_res_q   <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      prod_q       <= prod_d;
      cnt_q        <= cnt_d;
      exp_q        <= exp_d;
      sign_q       <= sign_d;
      spec_q       <= spec_d;
      spec_res_q   <= spec_res_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign can_accept_cmd = (state_q == StIdle);
  assign data_valid     = data_valid_q;
  assign data           = data_q;
endmodule

// File: tb/tb_snow64_float_mul_param.sv
// Bench for snow64_float_mul_param (bfloat16): truncating and RNE instances
// driven in parallel and compared against an integer-arithmetic model.
module tb_snow64_float_mul_param;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cac0, dv0, cac1, dv1;
  logic [15:0] d0, d1;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  snow64_float_mul_param #(.ROUND_NEAREST(0)) u_trunc (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .can_accept_cmd(cac0), .data_valid(dv0), .data(d0));
  snow64_float_mul_param #(.ROUND_NEAREST(1)) u_rne (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .can_accept_cmd(cac1), .data_valid(dv1), .data(d1));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [15:0] x);
    return (x[14:7] == 8'h00) || (x[14:7] == 8'hFF);
  endfunction

  // Real-valued significand product, rounded by remainder comparison
  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input bit rne);
    int ex, ey, mx, my, e, sh, m, rem, half;
    longint p;
    bit s, xz, yz, xi, yi, xn, yn;
    ex = int'(x[14:7]); ey = int'(y[14:7]);
    mx = int'(x[6:0]);  my = int'(y[6:0]);
    s  = x[15] ^ y[15];
    xz = (ex == 0); yz = (ey == 0);
    xi = (ex == 255) && (mx == 0); yi = (ey == 255) && (my == 0);
    xn = (ex == 255) && (mx != 0); yn = (ey == 255) && (my != 0);
    if (xn || yn || (xi && yz) || (yi && xz)) return 16'h7FC0;
    if (xi || yi) return {s, 15'h7F80};
    if (xz || yz) return {s, 15'h0000};
    p = longint'(128 + mx) * longint'(128 + my);
    e = ex + ey - 127;
    if (p >= 32768) begin e++; sh = 8; end else sh = 7;
    m    = int'(p >> sh) % 128;
    rem  = int'(p % (longint'(1) << sh));
    half = 1 << (sh - 1);
    if (rne && (rem > half || (rem == half && (m % 2) == 1))) m++;
    if (m == 128) begin m = 0; e++; end
    if (e >= 255) return {s, 15'h7F80};
    if (e <= 0)   return {s, 15'h0000};
    return {s, 8'(e), 7'(m)};
  endfunction

  // Issue one command (assumes idle), optionally poke start while busy
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input bit poke);
    int k;
    int exp_lat;
    exp_lat = (is_special(x) || is_special(y)) ? 1 : 9;
    chk("accept_ready", 16'(cac0), 16'd1);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", 16'(cac0), 16'd0);
    chk("strobe_one_cycle", 16'(dv0), 16'd0);
    for (k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (dv0) break;
      if (poke && k == 2) begin
        start = 1'b1; a = ~x; b = y ^ 16'h0101;
      end
    end
    chk("latency", 16'(k), 16'(exp_lat));
    chk("data_trunc", d0, ref_mul(x, y, 1'b0));
    chk("data_rne", d1, ref_mul(x, y, 1'b1));
    chk("valid_rne", 16'(dv1), 16'd1);
    chk("ready_with_valid", 16'(cac0), 16'd1);
  endtask

  initial begin
    int seen;
    logic [15:0] hold, x, y;
    #2;
    chk("reset_data", d0, 16'h0000);
    chk("reset_valid", 16'(dv0), 16'd0);
    chk("reset_ready", 16'(cac0), 16'd1);
    @(negedge clk); rst_n = 1'b1;

    run_op(16'h3F80, 16'h3F80, 1'b0); chk("one_times_one", d0, 16'h3F80);
    run_op(16'hC000, 16'h4040, 1'b0); chk("neg_two_times_three", d0, 16'hC0C0);
    run_op(16'h3FC0, 16'h3FC0, 1'b0); chk("one_five_sq", d1, 16'h4010);
    run_op(16'h3FC1, 16'h3FC1, 1'b0);
    chk("trunc_round", d0, 16'h4011); chk("rne_round", d1, 16'h4012);
    run_op(16'h7F00, 16'h7F00, 1'b0); chk("overflow", d0, 16'h7F80);
    run_op(16'h7F80, 16'h0000, 1'b0); chk("inf_times_zero", d0, 16'h7FC0);
    run_op(16'h0080, 16'h0080, 1'b0); chk("underflow", d0, 16'h0000);
    run_op(16'h4040, 16'h3FC0, 1'b1); chk("busy_poke_ignored", d0, 16'h4090);

    hold = d0;
    repeat (3) @(posedge clk);
    #1 chk("data_hold", d0, hold);
    chk("hold_no_strobe", 16'(dv0), 16'd0);

    // Reset in the middle of a multiply
    @(negedge clk);
    a = 16'h4000; b = 16'h4000; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_data", d0, 16'h0000);
    chk("midreset_valid", 16'(dv0), 16'd0);
    chk("midreset_ready", 16'(cac0), 16'd1);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (dv0 || dv1) seen++;
    end
    chk("no_stale_strobe", 16'(seen), 16'd0);

    // First accept right after release
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_op(16'hBF80, 16'h4000, 1'b0);

    for (int i = 0; i < 60; i++) begin
      x = 16'($urandom); y = 16'($urandom);
      if ($urandom_range(0, 7) == 0) x[14:7] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      if ($urandom_range(0, 7) == 0) y[14:7] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
      if ($urandom_range(0, 3) == 0) begin
        x[14:7] = 8'(120 + $urandom_range(0, 14));
        y[14:7] = 8'(120 + $urandom_range(0, 14));
      end
      run_op(x, y, ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/snow64_float_mul_param.md
SNOW64_FLOAT_MUL_PARAM -- requirements
Module: snow64_float_mul_param

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8: encoded exponent width.
REQ-002 SHALL have parameter MANT_WIDTH, default 7: encoded mantissa width, hidden bit excluded.
REQ-003 SHALL have parameter ROUND_NEAREST, default 0: 0 = truncate, 1 = round-to-nearest-even.
REQ-004 SHALL define W = 1+EXP_WIDTH+MANT_WIDTH, SIG_W = MANT_WIDTH+1, BIAS = 2^(EXP_WIDTH-1)-1; operand layout {sign, exp, mantissa}, MSB first.
REQ-005 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  command request.
- a  in  W  operand A.
- b  in  W  operand B.
- can_accept_cmd  out  1  high when start will be accepted.
- data_valid  out  1  one-cycle result strobe.
- data  out  W  result.

Function
REQ-006 SHALL use states StIdle, StMultiplying, StFinishing.
REQ-007 SHALL drive can_accept_cmd = 1 exactly when state is StIdle, including the cycle in which data_valid is high.
REQ-008 SHALL accept a command on a rising edge with start=1 and state StIdle, capturing a and b.
REQ-009 SHALL ignore start in any other state, with no effect on the operation in progress.
REQ-010 SHALL compute the result sign as sign(a) XOR sign(b) for every non-NaN result.
REQ-011 SHALL treat exp==0 as zero, flushing denormals.
REQ-012 SHALL treat exp all-ones with mantissa==0 as infinity.
REQ-013 SHALL treat exp all-ones with mantissa!=0 as NaN.
REQ-014 Special operands SHALL be resolved at acceptance as follows, and the FSM SHALL go straight to StFinishing:
- any NaN, or infinity times zero -> canonical NaN (sign 0, exp all-ones, mantissa MSB 1, others 0).
- otherwise any infinity -> signed infinity.
- otherwise any zero -> signed zero.
REQ-015 For normal operands, acceptance SHALL go to StMultiplying and load the significands {1, mantissa}.
REQ-016 StMultiplying SHALL run a shift-add multiplier, one multiplier bit per cycle, for exactly SIG_W cycles, producing a 2*SIG_W-bit product P; it SHALL then go to StFinishing.
REQ-017 The exponent SHALL be computed as E = expA + expB - BIAS, signed, at least EXP_WIDTH+2 bits wide.
REQ-018 Normalisation:
- if P[2*SIG_W-1]=1: E += 1, mantissa = P[2*SIG_W-2 -: MANT_WIDTH].
- otherwise: mantissa = P[2*SIG_W-3 -: MANT_WIDTH].
REQ-019 With ROUND_NEAREST=1, rounding SHALL use guard = the next lower product bit and sticky = OR of all remaining bits.
REQ-020 The mantissa SHALL be incremented when guard=1 and (sticky=1 or mantissa LSB=1).
REQ-021 A rounding carry-out SHALL set the mantissa to 0 and increment E.
REQ-022 After rounding, E >= 2^EXP_WIDTH-1 SHALL give signed infinity (overflow).
REQ-023 After rounding, E <= 0 SHALL give signed zero (underflow).
REQ-024 StFinishing SHALL register data, set data_valid=1 for exactly one cycle, and return to StIdle, all on one edge.
REQ-025 Latency, counted in edges from the accepting edge to the edge that raises data_valid, SHALL be:
- normal operands: SIG_W+1.
- special operands: 1.
REQ-026 data SHALL hold the last result until the next result is registered.
REQ-027 A start in the cycle where data_valid=1 SHALL be accepted, giving back-to-back operation.

Reset
REQ-028 rst_n=0 SHALL immediately, asynchronously, force: state StIdle, data_valid=0, data=0, can_accept_cmd=1, internal multiplier registers cleared.
REQ-029 Reset asserted mid-operation SHALL abandon that operation; no data_valid SHALL appear for it after release.
REQ-030 The first command SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (bfloat16 defaults unless stated)
REQ-031 a=0x3F80, b=0x3F80, start for 1 cycle -> data=0x3F80; data_valid on the 9th edge after acceptance, for 1 cycle.
REQ-032 a=0xC000, b=0x4040 -> data=0xC0C0.
REQ-033 a=0x3FC0, b=0x3FC0 -> data=0x4010.
REQ-034 a=0x3FC1, b=0x3FC1 -> data=0x4011 with ROUND_NEAREST=0; data=0x4012 with ROUND_NEAREST=1.
REQ-035 a=0x7F00, b=0x7F00 -> data=0x7F80 (overflow).
REQ-036 a=0x7F80, b=0x0000 -> data=0x7FC0 one edge after acceptance.
REQ-037 Busy and reset handling:
- start with different operands pulsed while busy -> ignored; original result delivered.
- rst_n pulsed low at cycle 4 of an operation -> data=0, data_valid=0, can_accept_cmd=1, and no stale strobe after release.
